// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register of the RV32IM core.
// Holds one instruction behind a valid/ready handshake. It selects the ALU
// operands (rs/pc/imm), forwards results from MEM and WB, inserts load-use
// bubbles and supports flush.
// Optional build macro: FORWARDING_EN. When it is defined, results from MEM
// and WB are forwarded onto ex_*. When it is undefined, any MEM or WB
// producer of a used source stalls the stage instead.
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [XLEN-1:0]     id_pc,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic [XLEN-1:0]     id_rs1_data,
  input  logic [XLEN-1:0]     id_rs2_data,
  input  logic [XLEN-1:0]     id_imm,
  input  logic                id_use_pc,
  input  logic                id_use_imm,
  input  logic [ALU_OP_W-1:0] id_alu_op,
  input  logic [4:0]          id_rd,
  input  logic                id_reg_write,
  input  logic                id_mem_read,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [XLEN-1:0]     ex_a,
  output logic [XLEN-1:0]     ex_b,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic [XLEN-1:0]     ex_rs2_fwd,
  output logic [4:0]          ex_rd,
  output logic                ex_reg_write,
  output logic                ex_mem_read,
  input  logic                mem_fwd_valid,
  input  logic [4:0]          mem_rd,
  input  logic [XLEN-1:0]     mem_result,
  input  logic                mem_is_load,
  input  logic                wb_fwd_valid,
  input  logic [4:0]          wb_rd,
  input  logic [XLEN-1:0]     wb_data
);

  logic                valid_q;
  logic [XLEN-1:0]     pc_q, imm_q, rs1_data_q, rs2_data_q;
  logic [4:0]          rs1_q, rs2_q, rd_q;
  logic                use_pc_q, use_imm_q, reg_write_q, mem_read_q;
  logic [ALU_OP_W-1:0] alu_op_q;

  logic            rs1_mem_hit, rs2_mem_hit, rs1_wb_hit, rs2_wb_hit;
  logic            id_rs1_wb_hit, id_rs2_wb_hit;
  logic            hazard, stall, capture;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;

  // producer matches against held sources (x0 never matches)
  assign rs1_mem_hit = mem_fwd_valid & (mem_rd != 5'd0) & (mem_rd == rs1_q);
  assign rs2_mem_hit = mem_fwd_valid & (mem_rd != 5'd0) & (mem_rd == rs2_q);
  assign rs1_wb_hit  = wb_fwd_valid & (wb_rd != 5'd0) & (wb_rd == rs1_q);
  assign rs2_wb_hit  = wb_fwd_valid & (wb_rd != 5'd0) & (wb_rd == rs2_q);

  // WB write in the same cycle as capture would be missed by the regfile read
  assign id_rs1_wb_hit = wb_fwd_valid & (wb_rd != 5'd0) & (wb_rd == id_rs1);
  assign id_rs2_wb_hit = wb_fwd_valid & (wb_rd != 5'd0) & (wb_rd == id_rs2);

`ifdef FORWARDING_EN
  // rs2 always counts as used because store data depends on it
  assign hazard  = mem_is_load & ((rs1_mem_hit & ~use_pc_q) | rs2_mem_hit);
  assign rs1_fwd = (rs1_mem_hit & ~mem_is_load) ? mem_result :
                   rs1_wb_hit ? wb_data : rs1_data_q;
  assign rs2_fwd = (rs2_mem_hit & ~mem_is_load) ? mem_result :
                   rs2_wb_hit ? wb_data : rs2_data_q;
`else
  // no bypass network: wait until the WB snoop has refreshed the operand
  logic            unused_fwd_in;
  assign unused_fwd_in = ^{mem_result, mem_is_load};
  assign hazard  = ((rs1_mem_hit | rs1_wb_hit) & ~use_pc_q) | rs2_mem_hit | rs2_wb_hit;
  assign rs1_fwd = rs1_data_q;
  assign rs2_fwd = rs2_data_q;
`endif

  assign stall    = valid_q & hazard;
  assign id_ready = ~valid_q | (ex_ready & ~stall);
  assign capture  = id_valid & id_ready & ~flush;

  assign ex_valid     = valid_q & ~hazard;
  assign ex_a         = use_pc_q  ? pc_q  : rs1_fwd;
  assign ex_b         = use_imm_q ? imm_q : rs2_fwd;
  assign ex_rs2_fwd   = rs2_fwd;
  assign ex_alu_op    = alu_op_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q;
  assign ex_mem_read  = mem_read_q;

  // valid tracking: flush beats capture, capture beats retire
  always_ff @(posedge clk) begin
    if (rst)                      valid_q <= 1'b0;
    else if (flush)               valid_q <= 1'b0;
    else if (capture)             valid_q <= 1'b1;
    else if (ex_valid & ex_ready) valid_q <= 1'b0;
  end

  // payload: load on capture, otherwise snoop WB writes into held operands
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      imm_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      use_pc_q    <= 1'b0;
      use_imm_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      alu_op_q    <= '0;
    end else if (capture) begin
      pc_q        <= id_pc;
      imm_q       <= id_imm;
      rs1_data_q  <= id_rs1_wb_hit ? wb_data : id_rs1_data;
      rs2_data_q  <= id_rs2_wb_hit ? wb_data : id_rs2_data;
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      use_pc_q    <= id_use_pc;
      use_imm_q   <= id_use_imm;
      reg_write_q <= id_reg_write;
      mem_read_q  <= id_mem_read;
      alu_op_q    <= id_alu_op;
    end else if (valid_q) begin
      if (rs1_wb_hit) rs1_data_q <= wb_data;
      if (rs2_wb_hit) rs2_data_q <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: random and directed stimulus for id_ex_stage, checked
// against a transaction-level model that holds at most one instruction.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst, flush, id_valid, id_ready;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_alu_op;
  logic        id_use_pc, id_use_imm, id_reg_write, id_mem_read;
  logic        ex_valid, ex_ready, ex_reg_write, ex_mem_read;
  logic [31:0] ex_a, ex_b, ex_rs2_fwd;
  logic [4:0]  ex_alu_op, ex_rd;
  logic        mem_fwd_valid, mem_is_load, wb_fwd_valid;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_data;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_use_pc(id_use_pc), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_a(ex_a), .ex_b(ex_b),
    .ex_alu_op(ex_alu_op), .ex_rs2_fwd(ex_rs2_fwd), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .mem_fwd_valid(mem_fwd_valid), .mem_rd(mem_rd), .mem_result(mem_result),
    .mem_is_load(mem_is_load), .wb_fwd_valid(wb_fwd_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd, op;
    logic        use_pc, use_imm, rw, mr;
  } instr_t;

  instr_t m_ins;
  bit     m_have;

  function automatic bit wb_writes(input logic [4:0] r);
    return wb_fwd_valid && wb_rd != 0 && wb_rd == r;
  endfunction

  function automatic bit mem_writes(input logic [4:0] r);
    return mem_fwd_valid && mem_rd != 0 && mem_rd == r;
  endfunction

  // value the ALU should see for a source register given its stale regfile copy
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] stale);
`ifdef FORWARDING_EN
    if (mem_writes(r) && !mem_is_load) return mem_result;
    if (wb_writes(r)) return wb_data;
`endif
    return stale;
  endfunction

  function automatic bit not_ready_source(input logic [4:0] r);
`ifdef FORWARDING_EN
    return mem_writes(r) && mem_is_load;
`else
    return mem_writes(r) || wb_writes(r);
`endif
  endfunction

  function automatic bit blocked();
    if (!m_ins.use_pc && not_ready_source(m_ins.rs1)) return 1'b1;
    return not_ready_source(m_ins.rs2);
  endfunction

  task automatic idle();
    rst = 0; flush = 0; id_valid = 0; ex_ready = 1;
    id_pc = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_use_pc = 0; id_use_imm = 0; id_alu_op = 0; id_rd = 0; id_reg_write = 0; id_mem_read = 0;
    mem_fwd_valid = 0; mem_rd = 0; mem_result = 0; mem_is_load = 0;
    wb_fwd_valid = 0; wb_rd = 0; wb_data = 0;
  endtask

  // check outputs against the model for the current inputs, then clock once
  task automatic step();
    bit exv, rdy, accept;
    instr_t nx;
    #1;
    exv = m_have && !blocked();
    rdy = !m_have || (ex_ready && !blocked());
    if (!rst) begin
      check("ex_valid", 32'(ex_valid), 32'(exv));
      check("id_ready", 32'(id_ready), 32'(rdy));
      if (exv) begin
        check("ex_a", ex_a, m_ins.use_pc ? m_ins.pc : operand(m_ins.rs1, m_ins.rs1d));
        check("ex_b", ex_b, m_ins.use_imm ? m_ins.imm : operand(m_ins.rs2, m_ins.rs2d));
        check("ex_rs2_fwd", ex_rs2_fwd, operand(m_ins.rs2, m_ins.rs2d));
        check("ex_op_rd", {ex_alu_op, ex_rd, ex_reg_write, ex_mem_read},
              {m_ins.op, m_ins.rd, m_ins.rw, m_ins.mr});
      end
    end
    accept = id_valid && rdy;
    nx = m_ins;
    if (rst) begin
      m_have = 0;
    end else if (flush) begin
      m_have = 0;
    end else if (accept) begin
      m_have = 1;
      nx.pc = id_pc; nx.imm = id_imm; nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.rd = id_rd;
      nx.op = id_alu_op; nx.use_pc = id_use_pc; nx.use_imm = id_use_imm;
      nx.rw = id_reg_write; nx.mr = id_mem_read;
      nx.rs1d = wb_writes(id_rs1) ? wb_data : id_rs1_data;
      nx.rs2d = wb_writes(id_rs2) ? wb_data : id_rs2_data;
    end else if (m_have) begin
      if (wb_writes(m_ins.rs1)) nx.rs1d = wb_data;
      if (wb_writes(m_ins.rs2)) nx.rs2d = wb_data;
      if (exv && ex_ready) m_have = 0;
    end
    @(posedge clk);
    m_ins = nx;
    @(negedge clk);
  endtask

  task automatic offer_add(input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [31:0] d1, input logic [31:0] d2);
    id_valid = 1; id_rs1 = rs1; id_rs2 = rs2; id_rs1_data = d1; id_rs2_data = d2;
    id_rd = 5'd3; id_reg_write = 1; id_alu_op = 5'd0; id_pc = 32'h100; id_imm = 32'h4;
    id_use_pc = 0; id_use_imm = 0; id_mem_read = 0;
  endtask

  initial begin
    idle();
    m_have = 0;
    @(negedge clk);
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
    check("rst_ex_valid", 32'(ex_valid), 32'd0);
    check("rst_ex_a", ex_a, 32'd0);
    check("rst_ex_b", ex_b, 32'd0);
    check("rst_id_ready", 32'(id_ready), 32'd1);
    check("rst_flags", {ex_alu_op, ex_rd, ex_reg_write, ex_mem_read, ex_rs2_fwd[21:0]}, 32'd0);

    // back-to-back ADDs at full throughput
    for (int i = 0; i < 4; i++) begin
      offer_add(5'd1, 5'd2, 32'd5, 32'd7);
      step();
      check("b2b_valid", 32'(ex_valid), 32'd1);
      check("b2b_a", ex_a, 32'd5);
      check("b2b_b", ex_b, 32'd7);
    end
    idle();
    step();

`ifdef FORWARDING_EN
    // MEM has priority over WB; x0 producer never forwards
    offer_add(5'd1, 5'd2, 32'h11, 32'h22);
    step();
    idle();
    ex_ready = 0;
    mem_fwd_valid = 1; mem_rd = 5'd1; mem_result = 32'h10;
    wb_fwd_valid = 1; wb_rd = 5'd1; wb_data = 32'h20;
    #1 check("fwd_mem_prio", ex_a, 32'h10);
    step();
    idle();
    ex_ready = 0;
    mem_fwd_valid = 1; mem_rd = 5'd0; mem_result = 32'h10;
    #1 check("fwd_x0", ex_a, 32'h20);
    ex_ready = 1;
    step();
    idle();
    step();
`endif

    // load-use bubble on rs2
    offer_add(5'd1, 5'd2, 32'd3, 32'd4);
    step();
    idle();
    mem_fwd_valid = 1; mem_is_load = 1; mem_rd = 5'd2;
    #1 check("lu_ex_valid", 32'(ex_valid), 32'd0);
    check("lu_id_ready", 32'(id_ready), 32'd0);
    step();
    idle();
    wb_fwd_valid = 1; wb_rd = 5'd2; wb_data = 32'h99;
`ifndef FORWARDING_EN
    step();
    idle();
`endif
    #1 check("lu_ex_b", ex_b, 32'h99);
    check("lu_resume", 32'(ex_valid), 32'd1);
    step();
    idle();

    // hold with ex_ready low; WB write to rs1 refreshes ex_a
    offer_add(5'd1, 5'd2, 32'd8, 32'd9);
    step();
    idle();
    ex_ready = 0;
    step();
    ex_ready = 0; wb_fwd_valid = 1; wb_rd = 5'd1; wb_data = 32'h55;
    step();
    idle();
    ex_ready = 0;
    #1 check("hold_ex_a", ex_a, 32'h55);
    check("hold_ex_b", ex_b, 32'd9);
    check("hold_id_ready", 32'(id_ready), 32'd0);
    step();

    // flush with a simultaneous offer kills both
    offer_add(5'd1, 5'd2, 32'd1, 32'd2);
    flush = 1;
    step();
    idle();
    #1 check("flush_ex_valid", 32'(ex_valid), 32'd0);
    step();

    // randomized traffic over a small register window to provoke matches
    for (int c = 0; c < 1500; c++) begin
      rst           = ($urandom_range(0, 199) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      id_valid      = ($urandom_range(0, 9) < 7);
      ex_ready      = ($urandom_range(0, 3) != 0);
      id_pc         = $urandom;
      id_imm        = $urandom;
      id_rs1        = 5'($urandom_range(0, 3));
      id_rs2        = 5'($urandom_range(0, 3));
      id_rs1_data   = $urandom;
      id_rs2_data   = $urandom;
      id_use_pc     = 1'($urandom);
      id_use_imm    = 1'($urandom);
      id_alu_op     = 5'($urandom);
      id_rd         = 5'($urandom);
      id_reg_write  = 1'($urandom);
      id_mem_read   = 1'($urandom);
      mem_fwd_valid = 1'($urandom);
      mem_rd        = 5'($urandom_range(0, 3));
      mem_result    = $urandom;
      mem_is_load   = ($urandom_range(0, 2) == 0);
      wb_fwd_valid  = 1'($urandom);
      wb_rd         = 5'($urandom_range(0, 3));
      wb_data       = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
